// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Load/store and instruction-fetch engine sitting between the multi-cycle
//   RV32I core FSM and the byte-wide system_ram. The core hands over one
//   request (byte, halfword or word, selected by the RISC-V funct3 width
//   code). The unit walks the individual RAM bytes in little-endian order,
//   assembles read bytes into a word or splits store data into bytes, applies
//   sign/zero extension to loads, and reports completion with a one-cycle
//   done pulse. Misaligned, out-of-range and illegal-width requests are
//   rejected with fault=1 before any RAM access is made.
//
// Parameters:
//   ADDR_WIDTH  - byte-address width of system_ram (width of ram_addr).
//   RAM_LATENCY - cycles from the edge that samples ram_addr/ram_rden until
//                 ram_q is valid; 1..3.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   req       in   request strobe, only looked at while idle
//   we        in   1 = store, 0 = load/fetch (captured with req)
//   funct3    in   width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr      in   32-bit byte address (captured with req)
//   wdata     in   store data, low bytes used (captured with req)
//   busy      out  high in every state except IDLE
//   done      out  one-cycle completion pulse
//   fault     out  valid with done; 1 = request rejected, no RAM access
//   rdata     out  extended load result, held until the next load completes
//   ram_addr  out  byte address to system_ram
//   ram_rden  out  RAM read enable
//   ram_wren  out  RAM write enable
//   ram_data  out  RAM write byte
//   ram_q     in   RAM read byte
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rden,
    output logic                  ram_wren,
    output logic [7:0]            ram_data,
    input  logic [7:0]            ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_ISSUE,
        RD_WAIT,
        WR_BYTE,
        DONE
    } state_t;

    // Value loaded into the wait counter when a read is issued; the counter
    // reaches zero in the last RD_WAIT cycle, when ram_q is valid.
    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

    // ------------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------------
    state_t                  state_reg;
    logic                    we_reg;
    logic [2:0]              funct3_reg;
    logic [31:0]             addr_reg;
    logic [31:0]             wdata_reg;
    logic [1:0]              cnt_reg;       // byte index i within the access
    logic [1:0]              lat_cnt_reg;   // remaining RD_WAIT cycles - 1
    logic [31:0]             asm_reg;       // little-endian read assembly

    // Registered outputs
    logic                    busy_reg;
    logic                    done_reg;
    logic                    fault_reg;
    logic [31:0]             rdata_reg;
    logic [ADDR_WIDTH-1:0]   ram_addr_reg;
    logic                    ram_rden_reg;
    logic                    ram_wren_reg;
    logic [7:0]              ram_data_reg;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic [1:0]            last_idx;       // n - 1
    logic                  last_byte;
    logic [1:0]            cnt_next;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  width_bad;
    logic                  unsigned_store;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  reject;

    always_comb begin
        case (funct3_reg[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    assign last_byte = (cnt_reg == last_idx);
    assign cnt_next  = cnt_reg + 2'd1;
    assign base_addr = addr_reg[ADDR_WIDTH-1:0];

    // 011, 110 and 111 are not load/store widths in RV32I.
    assign width_bad      = (funct3_reg == 3'b011) || (funct3_reg[2:1] == 2'b11);
    // The unsigned variants only exist for loads.
    assign unsigned_store = we_reg && funct3_reg[2];
    assign misaligned     = ((funct3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                            ((funct3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
    // Any address bit above the RAM's byte-address range is an error.
    assign out_of_range   = ((addr_reg >> ADDR_WIDTH) != 32'd0);
    assign reject         = width_bad || unsigned_store || misaligned || out_of_range;

    // ------------------------------------------------------------------------
    // Byte lanes
    //   lane_byte : the assembly register as it will look after this edge,
    //               i.e. with the byte arriving on ram_q already merged in.
    //               The extension logic works on this view so that rdata can
    //               be written on the same edge that captures the last byte.
    //   wbyte     : store data split into bytes.
    // ------------------------------------------------------------------------
    logic       capture;
    logic [7:0] lane_byte [4];
    logic [7:0] wbyte     [4];

    assign capture = (state_reg == RD_WAIT) && (lat_cnt_reg == 2'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_byte[gi] = (capture && (cnt_reg == 2'(gi))) ? ram_q
                                                                     : asm_reg[8*gi +: 8];
            assign wbyte[gi]     = wdata_reg[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Load extension
    // ------------------------------------------------------------------------
    logic [31:0] ext_data;

    always_comb begin
        ext_data = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};
        case (funct3_reg)
            3'b000:  ext_data = {{24{lane_byte[0][7]}}, lane_byte[0]};
            3'b001:  ext_data = {{16{lane_byte[1][7]}}, lane_byte[1], lane_byte[0]};
            3'b100:  ext_data = {24'd0, lane_byte[0]};
            3'b101:  ext_data = {16'd0, lane_byte[1], lane_byte[0]};
            default: ext_data = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};
        endcase
    end

    // ------------------------------------------------------------------------
    // Control FSM. All outputs are registered and set on the transition into
    // the state in which they must be visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'd0;
            addr_reg     <= 32'd0;
            wdata_reg    <= 32'd0;
            cnt_reg      <= 2'd0;
            lat_cnt_reg  <= 2'd0;
            asm_reg      <= 32'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fault_reg    <= 1'b0;
            rdata_reg    <= 32'd0;
            ram_addr_reg <= '0;
            ram_rden_reg <= 1'b0;
            ram_wren_reg <= 1'b0;
            ram_data_reg <= 8'd0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (req) begin
                        we_reg     <= we;
                        funct3_reg <= funct3;
                        addr_reg   <= addr;
                        wdata_reg  <= wdata;
                        cnt_reg    <= 2'd0;
                        busy_reg   <= 1'b1;
                        state_reg  <= CHECK;
                    end
                end

                CHECK: begin
                    if (reject) begin
                        done_reg  <= 1'b1;
                        fault_reg <= 1'b1;
                        state_reg <= DONE;
                    end else if (we_reg) begin
                        ram_addr_reg <= base_addr;
                        ram_data_reg <= wbyte[0];
                        ram_wren_reg <= 1'b1;
                        state_reg    <= WR_BYTE;
                    end else begin
                        ram_addr_reg <= base_addr;
                        ram_rden_reg <= 1'b1;
                        state_reg    <= RD_ISSUE;
                    end
                end

                RD_ISSUE: begin
                    // ram_addr stays put while waiting for the data.
                    ram_rden_reg <= 1'b0;
                    lat_cnt_reg  <= LAT_LAST;
                    state_reg    <= RD_WAIT;
                end

                RD_WAIT: begin
                    if (lat_cnt_reg != 2'd0) begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                    end else begin
                        asm_reg[8*cnt_reg +: 8] <= ram_q;
                        if (last_byte) begin
                            rdata_reg <= ext_data;
                            done_reg  <= 1'b1;
                            fault_reg <= 1'b0;
                            state_reg <= DONE;
                        end else begin
                            cnt_reg      <= cnt_next;
                            ram_addr_reg <= base_addr + ADDR_WIDTH'(cnt_next);
                            ram_rden_reg <= 1'b1;
                            state_reg    <= RD_ISSUE;
                        end
                    end
                end

                WR_BYTE: begin
                    if (last_byte) begin
                        ram_wren_reg <= 1'b0;
                        done_reg     <= 1'b1;
                        fault_reg    <= 1'b0;
                        state_reg    <= DONE;
                    end else begin
                        cnt_reg      <= cnt_next;
                        ram_addr_reg <= base_addr + ADDR_WIDTH'(cnt_next);
                        ram_data_reg <= wbyte[cnt_next];
                    end
                end

                DONE: begin
                    busy_reg  <= 1'b0;
                    fault_reg <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy_reg     <= 1'b0;
                    ram_rden_reg <= 1'b0;
                    ram_wren_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign fault    = fault_reg;
    assign rdata    = rdata_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_rden = ram_rden_reg;
    assign ram_wren = ram_wren_reg;
    assign ram_data = ram_data_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Two instances: index 0 with RAM_LATENCY=1, index 1 with RAM_LATENCY=3. Each
// has its own byte-wide RAM emulation. A reference model keeps a shadow copy
// of memory plus the outstanding transaction (start cycle, length, result) and
// derives every output from the cycle offset since the request was sampled.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DUT-side signals, one element per instance
    logic          rst_s   [2];
    logic          req_s   [2];
    logic          we_s    [2];
    logic [2:0]    f3_s    [2];
    logic [31:0]   addr_s  [2];
    logic [31:0]   wdata_s [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic          fault_s [2];
    logic [31:0]   rdata_s [2];
    logic [AW-1:0] raddr_s [2];
    logic          rden_s  [2];
    logic          wren_s  [2];
    logic [7:0]    rdat_s  [2];
    logic [7:0]    rq_s    [2];

    logic [7:0] ram_mem [2][65536];   // emulated system_ram contents
    logic [7:0] ref_mem [2][65536];   // model's view of memory

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [7:0] pipe [3];

        mem_access_unit #(.ADDR_WIDTH(AW), .RAM_LATENCY(LAT)) u_dut (
            .clk      (clk),
            .rst      (rst_s[gi]),
            .req      (req_s[gi]),
            .we       (we_s[gi]),
            .funct3   (f3_s[gi]),
            .addr     (addr_s[gi]),
            .wdata    (wdata_s[gi]),
            .busy     (busy_s[gi]),
            .done     (done_s[gi]),
            .fault    (fault_s[gi]),
            .rdata    (rdata_s[gi]),
            .ram_addr (raddr_s[gi]),
            .ram_rden (rden_s[gi]),
            .ram_wren (wren_s[gi]),
            .ram_data (rdat_s[gi]),
            .ram_q    (rq_s[gi])
        );

        // Read data appears LAT cycles after the sampling edge; garbage is
        // pushed when not reading so a mistimed capture shows up.
        assign rq_s[gi] = pipe[LAT-1];
        always @(posedge clk) begin
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            pipe[0] <= rden_s[gi] ? ram_mem[gi][raddr_s[gi]] : 8'($urandom);
            if (wren_s[gi]) ram_mem[gi][raddr_s[gi]] = rdat_s[gi];
        end
    end

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    bit          t_active  [2];
    bit          t_load    [2];
    bit          t_fault   [2];
    int          t_start   [2];
    int          t_drel    [2];
    logic [15:0] t_base    [2];
    logic [31:0] t_wdata   [2];
    logic [31:0] t_old     [2];
    logic [31:0] t_new     [2];
    logic [31:0] cur_rdata [2];

    // Observations for literal checks
    int   done_cyc   [2];
    int   rden_cnt   [2];
    int   wren_cnt   [2];
    logic last_fault [2];

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%08h want=%08h", name, k, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(int k, logic [2:0] f3, logic [15:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[k][a];
        b1 = ref_mem[k][a + 16'd1];
        b2 = ref_mem[k][a + 16'd2];
        b3 = ref_mem[k][a + 16'd3];
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Compare process: every falling edge, every instance
    // ------------------------------------------------------------------------
    always @(negedge clk) begin : compare
        int          rel, idx, per;
        logic        eb, ed, er, ew;
        logic [15:0] ea;
        logic [7:0]  edat;
        logic [31:0] erd;
        for (int k = 0; k < 2; k++) begin
            if (done_s[k]) begin
                done_cyc[k]   = cyc;
                last_fault[k] = fault_s[k];
            end
            if (rden_s[k]) rden_cnt[k]++;
            if (wren_s[k]) wren_cnt[k]++;

            eb = 0; ed = 0; er = 0; ew = 0; ea = '0; edat = '0;
            erd = cur_rdata[k];
            if (t_active[k]) begin
                rel = cyc - t_start[k];
                per = 1 + lat_of(k);
                eb  = (rel >= 1) && (rel <= t_drel[k]);
                ed  = (rel == t_drel[k]);
                erd = (rel >= t_drel[k]) ? t_new[k] : t_old[k];
                if (!t_fault[k] && rel >= 2 && rel < t_drel[k]) begin
                    if (t_load[k]) begin
                        idx = (rel - 2) / per;
                        er  = ((rel - 2) % per) == 0;
                    end else begin
                        idx  = rel - 2;
                        ew   = 1;
                        edat = 8'(t_wdata[k] >> (8 * idx));
                    end
                    ea = t_base[k] + 16'(idx);
                    chk("ram_addr", k, 32'(raddr_s[k]), 32'(ea));
                end
                if (ed) chk("fault", k, 32'(fault_s[k]), 32'(t_fault[k]));
            end
            chk("busy", k, 32'(busy_s[k]), 32'(eb));
            chk("done", k, 32'(done_s[k]), 32'(ed));
            chk("ram_rden", k, 32'(rden_s[k]), 32'(er));
            chk("ram_wren", k, 32'(wren_s[k]), 32'(ew));
            if (ew) chk("ram_data", k, 32'(rdat_s[k]), 32'(edat));
            chk("rdata", k, rdata_s[k], erd);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (call at a falling edge)
    // ------------------------------------------------------------------------
    task automatic start_txn(input int k, input bit w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int t, output int drel);
        bit          flt;
        int          n;
        logic [31:0] nv;
        flt = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (w && (f3 == 3'b100 || f3 == 3'b101)) ||
              ((f3 == 3'b001 || f3 == 3'b101) && a[0]) ||
              ((f3 == 3'b010) && (a[1:0] != 2'b00)) ||
              (a[31:16] != 16'h0);
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        drel = flt ? 2 : (w ? 2 + n : 2 + n * (1 + lat_of(k)));
        nv = cur_rdata[k];
        if (!flt && !w) nv = ref_load(k, f3, a[15:0]);
        if (!flt && w)
            for (int i = 0; i < n; i++) ref_mem[k][a[15:0] + 16'(i)] = wd[8*i +: 8];

        t            = cyc;
        t_start[k]   = cyc;
        t_drel[k]    = drel;
        t_load[k]    = !w;
        t_fault[k]   = flt;
        t_base[k]    = a[15:0];
        t_wdata[k]   = wd;
        t_old[k]     = cur_rdata[k];
        t_new[k]     = nv;
        t_active[k]  = 1;
        cur_rdata[k] = nv;
        rden_cnt[k]  = 0;
        wren_cnt[k]  = 0;
        done_cyc[k]  = -1;

        req_s[k]   = 1'b1;
        we_s[k]    = w;
        f3_s[k]    = f3;
        addr_s[k]  = a;
        wdata_s[k] = wd;
        $display("txn inst%0d T=%0d we=%0b f3=%03b addr=%08h wdata=%08h expect fault=%0b rdata=%08h done=T+%0d",
                 k, t, w, f3, a, wd, flt, nv, drel);
    endtask

    task automatic issue(input int k, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit drop_req, output int t);
        int drel;
        start_txn(k, w, f3, a, wd, t, drel);
        @(negedge clk);
        if (drop_req) req_s[k] = 1'b0;
        repeat (drel) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        int          t, drel;
        int          r;
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  fl_f3 [5];
        logic [31:0] fl_a  [5];
        bit          fl_we [5];

        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1; req_s[k] = 1'b0; we_s[k] = 1'b0; f3_s[k] = 3'd0;
            addr_s[k] = 32'd0; wdata_s[k] = 32'd0;
            t_active[k] = 0; cur_rdata[k] = 32'd0; done_cyc[k] = -1;
            rden_cnt[k] = 0; wren_cnt[k] = 0; last_fault[k] = 1'b0;
            for (int i = 0; i < 65536; i++) begin
                ram_mem[k][i] = 8'($urandom);
                ref_mem[k][i] = ram_mem[k][i];
            end
            ram_mem[k][16'h100] = 8'h78; ram_mem[k][16'h101] = 8'h56;
            ram_mem[k][16'h102] = 8'h34; ram_mem[k][16'h103] = 8'h12;
            ram_mem[k][16'h205] = 8'h80; ram_mem[k][16'h206] = 8'hFE;
            ram_mem[k][16'h207] = 8'hFF;
            for (int i = 16'h100; i < 16'h208; i++) ref_mem[k][i] = ram_mem[k][i];
        end
        #1;
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_rdata", k, rdata_s[k], 32'h0);
            chk("reset_ram_addr", k, 32'(raddr_s[k]), 32'h0);
            chk("reset_busy", k, 32'(busy_s[k]), 32'h0);
        end
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        @(negedge clk);

        // Word load, both latencies
        issue(0, 0, 3'b010, 32'h100, 32'h0, 1, t);
        chk("lw_rdata", 0, rdata_s[0], 32'h12345678);
        chk("lw_done_lat", 0, done_cyc[0] - t, 10);
        chk("lw_rden_pulses", 0, rden_cnt[0], 4);
        chk("lw_fault", 0, 32'(last_fault[0]), 32'h0);
        issue(1, 0, 3'b010, 32'h100, 32'h0, 1, t);
        chk("lw_rdata", 1, rdata_s[1], 32'h12345678);
        chk("lw_done_lat", 1, done_cyc[1] - t, 18);

        // Extension
        issue(0, 0, 3'b000, 32'h205, 32'h0, 1, t);
        chk("lb_rdata", 0, rdata_s[0], 32'hFFFFFF80);
        issue(0, 0, 3'b100, 32'h205, 32'h0, 1, t);
        chk("lbu_rdata", 0, rdata_s[0], 32'h00000080);
        issue(1, 0, 3'b001, 32'h206, 32'h0, 1, t);
        chk("lh_rdata", 1, rdata_s[1], 32'hFFFFFFFE);
        issue(0, 0, 3'b101, 32'h206, 32'h0, 1, t);
        chk("lhu_rdata", 0, rdata_s[0], 32'h0000FFFE);

        // Word store then read back
        issue(0, 1, 3'b010, 32'h010, 32'hDEADBEEF, 1, t);
        chk("sw_wren_pulses", 0, wren_cnt[0], 4);
        chk("sw_done_lat", 0, done_cyc[0] - t, 6);
        chk("sw_rdata_kept", 0, rdata_s[0], 32'h0000FFFE);
        issue(0, 0, 3'b010, 32'h010, 32'h0, 1, t);
        chk("sw_readback", 0, rdata_s[0], 32'hDEADBEEF);

        // Rejected requests
        fl_we[0] = 0; fl_f3[0] = 3'b010; fl_a[0] = 32'h102;
        fl_we[1] = 0; fl_f3[1] = 3'b001; fl_a[1] = 32'h101;
        fl_we[2] = 0; fl_f3[2] = 3'b011; fl_a[2] = 32'h100;
        fl_we[3] = 1; fl_f3[3] = 3'b000; fl_a[3] = 32'h00010000;
        fl_we[4] = 1; fl_f3[4] = 3'b100; fl_a[4] = 32'h100;
        for (int i = 0; i < 5; i++) begin
            issue(0, fl_we[i], fl_f3[i], fl_a[i], 32'h55AA55AA, 1, t);
            chk("fault_flag", 0, 32'(last_fault[0]), 32'h1);
            chk("fault_done_lat", 0, done_cyc[0] - t, 2);
            chk("fault_ram_activity", 0, rden_cnt[0] + wren_cnt[0], 0);
            chk("fault_rdata_kept", 0, rdata_s[0], 32'hDEADBEEF);
        end

        // req held high across a whole load and into the next one
        issue(0, 0, 3'b010, 32'h100, 32'h0, 0, t);
        chk("held_first_lat", 0, done_cyc[0] - t, 10);
        issue(0, 0, 3'b010, 32'h100, 32'h0, 1, t);
        chk("held_second_lat", 0, done_cyc[0] - t, 10);
        chk("held_second_rden", 0, rden_cnt[0], 4);

        // Asynchronous reset in the RD_WAIT of byte 2
        start_txn(0, 0, 3'b010, 32'h100, 32'h0, t, drel);
        @(negedge clk);
        req_s[0] = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_s[0] = 1'b0;
        t_active[0] = 0;
        cur_rdata[0] = 32'h0;
        #1;
        chk("arst_busy", 0, 32'(busy_s[0]), 32'h0);
        chk("arst_done", 0, 32'(done_s[0]), 32'h0);
        chk("arst_rden", 0, 32'(rden_s[0]), 32'h0);
        chk("arst_wren", 0, 32'(wren_s[0]), 32'h0);
        chk("arst_rdata", 0, rdata_s[0], 32'h0);
        chk("arst_ram_addr", 0, 32'(raddr_s[0]), 32'h0);
        repeat (2) @(negedge clk);
        #2;
        rst_s[0] = 1'b1;
        @(negedge clk);
        issue(0, 0, 3'b000, 32'h205, 32'h0, 1, t);
        chk("post_rst_lb", 0, rdata_s[0], 32'hFFFFFF80);
        chk("post_rst_lb_lat", 0, done_cyc[0] - t, 4);

        // Random mix, both latencies
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 60; j++) begin
                r = $urandom_range(0, 15);
                f3 = (r < 4) ? 3'b010 : (r < 7) ? 3'b001 : (r < 10) ? 3'b000 :
                     (r < 12) ? 3'b100 : (r < 14) ? 3'b101 : (r == 14) ? 3'b011 : 3'b110;
                w = ($urandom_range(0, 9) < 4);
                a = 32'h300 + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) >= 2) begin
                    if (f3[1:0] == 2'b01) a[0] = 1'b0;
                    if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                end
                if ($urandom_range(0, 19) == 0) a[31:16] = 16'($urandom_range(1, 65535));
                issue(k, w, f3, a, $urandom(), 1, t);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // Final memory image must match the model
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16'h400; i++)
                chk("mem_image", k, 32'(ram_mem[k][i]), 32'(ref_mem[k][i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store and fetch engine between the multi-cycle RV32I core FSM and the byte-wide system_ram.
- The core issues one request for a byte, halfword or word, with a RISC-V funct3 width code.
- The unit sequences the per-byte RAM accesses in little-endian order, assembles or splits the data, and applies sign or zero extension.
- It returns the result with a one-cycle done pulse and flags misaligned, out-of-range or illegal-width requests.

Parameters:
- ADDR_WIDTH, 16: byte-address width of system_ram; also the width of ram_addr.
- RAM_LATENCY, 1: clock cycles from the edge that samples ram_addr/ram_rden to valid ram_q; legal range 1..3.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- req, input, 1: request strobe; sampled only in IDLE.
- we, input, 1: 1 = store, 0 = load/fetch; captured with req.
- funct3, input, 3: width code. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. Captured with req.
- addr, input, 32: byte address; captured with req.
- wdata, input, 32: store data, low bytes used; captured with req.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle completion pulse.
- fault, output, 1: valid with done; 1 = request rejected, no RAM access made.
- rdata, output, 32: extended load result; valid from done, held until the next accepted req.
- ram_addr, output, ADDR_WIDTH: byte address to system_ram.
- ram_rden, output, 1: RAM read enable.
- ram_wren, output, 1: RAM write enable.
- ram_data, output, 8: RAM write byte.
- ram_q, input, 8: RAM read byte.

Behaviour:
- Reset: asynchronous on rst low, takes effect immediately even mid-operation.
  - State goes to IDLE.
  - busy, done, fault, ram_rden and ram_wren are 0.
  - rdata, ram_addr, ram_data and the byte counter are 0.
  - An interrupted store may leave partially written bytes; this is acceptable.
- State machine: IDLE, CHECK, RD_ISSUE, RD_WAIT, WR_BYTE, DONE.
- IDLE:
  - When req=1, capture we/funct3/addr/wdata and clear the counter; next state is CHECK.
  - req while busy is ignored and not queued.
- CHECK: one cycle. Set n = 1, 2 or 4 bytes from funct3[1:0]. Fault if any of:
  - funct3 is 011, 110 or 111;
  - funct3 = 100 or 101 with we=1;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:ADDR_WIDTH] ≠ 0.
  - On fault, go to DONE with fault=1. Otherwise go to RD_ISSUE (we=0) or WR_BYTE (we=1).
- RD_ISSUE: one cycle. ram_addr = addr[ADDR_WIDTH-1:0] + i; ram_rden = 1.
- RD_WAIT: RAM_LATENCY cycles.
  - ram_rden = 0 and ram_addr is held.
  - At the edge ending the last RD_WAIT cycle, ram_q is written into byte lane i of the assembly register.
  - If i = n−1, go to DONE; otherwise i+1 and return to RD_ISSUE.
- WR_BYTE: one cycle per byte.
  - ram_wren = 1, ram_addr = base + i, ram_data = wdata[8i+7:8i].
  - After byte n−1, go to DONE.
- ram_rden and ram_wren are never high simultaneously and are low outside RD_ISSUE/WR_BYTE.
- Extension, applied on entry to DONE for loads:
  - LB sign-extends bit 7; LH sign-extends bit 15.
  - LBU and LHU zero-extend; LW passes all 32 bits.
- DONE: one cycle with done = 1 and fault valid, then IDLE.
  - rdata is updated only for a non-faulting load; stores and faults leave rdata unchanged.
- Latency, with req sampled at the end of cycle T:
  - done is high in cycle T+2+n·(1+RAM_LATENCY) for loads and T+2+n for stores.
  - A fault gives done in cycle T+2.
  - busy is high from T+1 through the done cycle.
  - The earliest next req is sampled in the cycle after done.
- Address arithmetic: base + i stays within ADDR_WIDTH bits. An aligned access cannot cross the top of memory, so no wrap occurs.

Test Plan:
- Bytes 0x100..0x103 preloaded with 78,56,34,12; LW (funct3=010) at addr 0x100, RAM_LATENCY=1 → 4 ram_rden pulses at 0x100..0x103; done at T+10; rdata=0x12345678; fault=0.
- Byte 0x205=0x80; LB then LBU at 0x205 → rdata=0xFFFFFF80, then 0x00000080. Bytes 0x206/0x207 = 0xFE/0xFF: LH gives 0xFFFFFFFE, LHU gives 0x0000FFFE.
- SW wdata=0xDEADBEEF at 0x010 → ram_wren high for 4 consecutive cycles; ram_addr/ram_data = 0x010/EF, 0x011/BE, 0x012/AD, 0x013/DE; done at T+6; a following LW returns 0xDEADBEEF.
- Each of LW at 0x102, LH at 0x101, funct3=011, SB at 0x00010000, LBU with we=1 → done+fault at T+2; no ram_rden/ram_wren activity; rdata unchanged.
- req held high continuously during an LW → exactly one transaction; the second req is accepted only after done. Random load/store mix checked against a byte-array model, with RAM_LATENCY=1 and =3.
- rst pulled low during the RD_WAIT of byte 2 of an LW → busy, done, ram_rden and ram_wren drop in the same cycle without a clock edge; after release, IDLE; a new LB completes normally.
